// File: rtl/clk_period_meter.sv
// Clock period / high-time meter: measures sigIn in clkIn cycles and hands
// each (period, highTime) pair to a consumer over a valid/ready handshake.
module clk_period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clkIn,
    input  logic             rstN,
    input  logic             sigIn,
    input  logic             en,
    input  logic             ready,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] highTime,
    output logic             valid,
    output logic             overrun,
    output logic             timeout
);
    typedef enum logic {ARM, MEASURE} meterStateE;

    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_LIMIT = {{(WIDTH-1){1'b1}}, 1'b0};

    meterStateE             state;
    meterStateE             nextState;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   sigPrev;
    logic                   sigSync;
    logic                   rise;
    logic                   fall;
    logic [WIDTH-1:0]       periodCnt;
    logic [WIDTH-1:0]       highCnt;
    logic                   highDone;
    logic                   restartCnt;
    logic                   stepCnt;
    logic                   complete;
    logic                   limitHit;

    assign sigSync = syncQ[SYNC_STAGES-1];
    assign rise    = sigSync & ~sigPrev;
    assign fall    = ~sigSync & sigPrev;

    // NOTE: non-blocking assignments let each stage take its neighbour's old value,
    // so the chain really is SYNC_STAGES flops deep rather than collapsing to one.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            syncQ   <= '0;
            sigPrev <= 1'b0;
        end else begin
            syncQ   <= {syncQ[SYNC_STAGES-2:0], sigIn};
            sigPrev <= sigSync;
        end
    end

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state <= ARM;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        if (!en) begin
            nextState = ARM;
        end else begin
            case (state)
                ARM:     if (rise) nextState = MEASURE;
                MEASURE: if (!rise && periodCnt == CNT_LIMIT) nextState = ARM;
                default: nextState = ARM;
            endcase
        end
    end

    always_comb begin
        restartCnt = 1'b0;
        stepCnt    = 1'b0;
        complete   = 1'b0;
        limitHit   = 1'b0;
        if (en) begin
            case (state)
                ARM: restartCnt = rise;
                MEASURE: begin
                    if (rise) begin
                        restartCnt = 1'b1;
                        // A period without a fall has no meaningful high time.
                        complete   = highDone;
                    end else begin
                        stepCnt  = 1'b1;
                        limitHit = (periodCnt == CNT_LIMIT);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            periodCnt <= '0;
            highCnt   <= '0;
            highDone  <= 1'b0;
        end else if (restartCnt) begin
            periodCnt <= CNT_ONE;
            highCnt   <= CNT_ONE;
            highDone  <= 1'b0;
        end else if (stepCnt) begin
            periodCnt <= periodCnt + CNT_ONE;
            if (fall) begin
                highDone <= 1'b1;
            end else if (!highDone) begin
                highCnt <= highCnt + CNT_ONE;
            end
        end
    end

    // A new result may replace the held one only when it is accepted this cycle.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            period   <= '0;
            highTime <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= limitHit;
            if (complete && (!valid || ready)) begin
                period   <= periodCnt;
                highTime <= highCnt;
                valid    <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: a divider table fed through a scoreboard, plus
// hand-written handshake, enable, reset and timeout sequences.
module tb_clk_period_meter;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    logic             clkIn = 1'b0;
    logic             rstN;
    logic             sigIn;
    logic             en;
    logic             ready;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] highTime;
    logic             valid;
    logic             overrun;
    logic             timeout;

    clk_period_meter #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clkIn(clkIn), .rstN(rstN), .sigIn(sigIn), .en(en), .ready(ready),
        .period(period), .highTime(highTime), .valid(valid),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        int unsigned per;
        int unsigned high;
    } resultT;

    typedef struct {
        int          lowLen;
        int          highLen;
        int          periods;
        int unsigned expPeriod;
        int unsigned expHigh;
    } vectorT;

    resultT      expQ[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          modelArmed = 0;
    bit          fallSeen = 0;
    bit          pushOn = 1;
    bit          monOn = 0;
    int unsigned riseCyc = 0;
    int unsigned highLen = 0;
    int          resultCount = 0;
    int unsigned lastPeriod = 0;
    int unsigned lastHigh = 0;

    always @(posedge clkIn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives sigIn for one cycle and keeps the reference model of rises/falls.
    task automatic drive(input logic v);
        @(posedge clkIn);
        #1;
        if (v && !sigIn) begin
            if (modelArmed && fallSeen && pushOn) expQ.push_back('{cyc - riseCyc, highLen});
            modelArmed = 1;
            riseCyc    = cyc;
            fallSeen   = 0;
        end else if (!v && sigIn && !fallSeen) begin
            highLen  = cyc - riseCyc;
            fallSeen = 1;
        end
        sigIn = v;
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clkIn);
            #1;
        end
    endtask

    task automatic runPeriods(input int lowLen, input int hiLen, input int n);
        repeat (n) begin
            repeat (lowLen) drive(1'b0);
            repeat (hiLen) drive(1'b1);
        end
    endtask

    task automatic rearm();
        drive(1'b0);
        hold(4);
        en = 1'b0;
        modelArmed = 0;
        hold(3);
        en = 1'b1;
        hold(2);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && expQ.size() != 0; i++) @(negedge clkIn);
        check(name, expQ.size(), 0);
    endtask

    initial begin : monitor
        resultT e;
        forever begin
            @(negedge clkIn);
            if (monOn && valid && ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result period=%0d highTime=%0d expected=none", period, highTime);
                end else begin
                    e = expQ.pop_front();
                    check("sb_period", 32'(period), e.per);
                    check("sb_highTime", 32'(highTime), e.high);
                end
                resultCount++;
                lastPeriod = 32'(period);
                lastHigh   = 32'(highTime);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=stuck expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vectorT      vecs[5];
        int          startCount;
        int          timeouts;
        int unsigned k;
        int unsigned firstAt;

        vecs[0] = '{50, 51, 5, 101, 51};
        vecs[1] = '{1, 1, 6, 2, 1};
        vecs[2] = '{10, 5, 4, 15, 5};
        vecs[3] = '{127, 127, 3, 254, 127};
        vecs[4] = '{3, 200, 3, 203, 200};

        rstN = 1'b0; sigIn = 1'b0; en = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clkIn);
        check("rst_period", 32'(period), 0);
        check("rst_highTime", 32'(highTime), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(timeout), 0);
        rstN = 1'b1; en = 1'b1; monOn = 1;
        hold(2);

        for (int i = 0; i < 5; i++) begin
            rearm();
            startCount = resultCount;
            runPeriods(vecs[i].lowLen, vecs[i].highLen, vecs[i].periods);
            drain($sformatf("drain_vec%0d", i));
            check($sformatf("count_vec%0d", i), resultCount - startCount, vecs[i].periods - 1);
            check($sformatf("period_vec%0d", i), lastPeriod, vecs[i].expPeriod);
            check($sformatf("high_vec%0d", i), lastHigh, vecs[i].expHigh);
            check($sformatf("overrun_vec%0d", i), 32'(overrun), 0);
        end

        // Completion in the very cycle the held result is accepted.
        rearm();
        pushOn = 0; monOn = 0; ready = 1'b0;
        runPeriods(50, 51, 1);
        runPeriods(30, 40, 1);
        @(negedge clkIn);
        check("swap_pre_valid", 32'(valid), 1);
        check("swap_pre_period", 32'(period), 81);
        repeat (25) drive(1'b0);
        drive(1'b1);
        repeat (SYNC) @(posedge clkIn);
        #1 ready = 1'b1;
        @(negedge clkIn);
        check("swap_hold_valid", 32'(valid), 1);
        check("swap_hold_period", 32'(period), 81);
        @(negedge clkIn);
        check("swap_new_valid", 32'(valid), 1);
        check("swap_new_period", 32'(period), 65);
        check("swap_new_high", 32'(highTime), 40);
        check("swap_overrun", 32'(overrun), 0);
        @(negedge clkIn);
        check("swap_clear_valid", 32'(valid), 0);

        // Back-pressure: later completions are dropped and flagged.
        rearm();
        ready = 1'b0;
        runPeriods(50, 51, 2);
        @(negedge clkIn);
        check("bp_first_valid", 32'(valid), 1);
        check("bp_first_period", 32'(period), 101);
        check("bp_first_overrun", 32'(overrun), 0);
        runPeriods(20, 30, 1);
        @(negedge clkIn);
        check("bp_drop_overrun", 32'(overrun), 1);
        check("bp_drop_period", 32'(period), 101);
        check("bp_drop_high", 32'(highTime), 51);
        runPeriods(50, 51, 1);
        @(negedge clkIn);
        check("bp_hold_valid", 32'(valid), 1);
        check("bp_hold_period", 32'(period), 101);
        ready = 1'b1;
        @(negedge clkIn);
        check("bp_accept_valid", 32'(valid), 0);
        pushOn = 1; monOn = 1;
        startCount = resultCount;
        runPeriods(50, 51, 1);
        drain("bp_drain");
        check("bp_fresh_count", resultCount - startCount, 1);
        check("bp_overrun_sticky", 32'(overrun), 1);

        // Enable dropped mid-period abandons that period.
        rearm();
        startCount = resultCount;
        runPeriods(50, 51, 2);
        repeat (10) drive(1'b0);
        en = 1'b0;
        modelArmed = 0;
        hold(20);
        en = 1'b1;
        repeat (20) drive(1'b0);
        repeat (51) drive(1'b1);
        runPeriods(50, 51, 1);
        drain("en_drain");
        check("en_count", resultCount - startCount, 2);
        check("en_period", lastPeriod, 101);

        // Short reset pulse mid-period while a result is held.
        rearm();
        pushOn = 0; monOn = 0; ready = 1'b0;
        runPeriods(50, 51, 2);
        @(negedge clkIn);
        check("prerst_valid", 32'(valid), 1);
        check("prerst_overrun", 32'(overrun), 1);
        repeat (10) drive(1'b0);
        @(negedge clkIn);
        rstN = 1'b0;
        #1;
        check("pulse_valid", 32'(valid), 0);
        check("pulse_period", 32'(period), 0);
        check("pulse_highTime", 32'(highTime), 0);
        check("pulse_overrun", 32'(overrun), 0);
        check("pulse_timeout", 32'(timeout), 0);
        @(negedge clkIn);
        rstN = 1'b1;
        modelArmed = 0;
        ready = 1'b1; pushOn = 1; monOn = 1;
        startCount = resultCount;
        repeat (30) drive(1'b0);
        repeat (51) drive(1'b1);
        runPeriods(50, 51, 1);
        drain("rst_drain");
        check("rst_count", resultCount - startCount, 1);
        check("rst_period_after", lastPeriod, 101);

        // Counter range exhausted: one timeout pulse, then back to ARM.
        rearm();
        startCount = resultCount;
        timeouts = 0;
        firstAt = 0;
        drive(1'b1);
        k = cyc;
        hold(4);
        drive(1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clkIn);
            if (timeout) begin
                timeouts++;
                if (timeouts == 1) firstAt = cyc - k;
            end
        end
        check("to_pulses", timeouts, 1);
        check("to_delay", firstAt, SYNC + 2 ** WIDTH - 1);
        check("to_no_result", resultCount - startCount, 0);
        modelArmed = 0;
        runPeriods(10, 10, 2);
        drain("to_drain");
        check("to_rearm_count", resultCount - startCount, 1);
        check("to_rearm_period", lastPeriod, 20);
        check("to_rearm_high", lastHigh, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter WIDTH, default 32: width of the period and high-time counters and their outputs.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of synchronizer flops on sigIn.
REQ-003 clkIn  input  1  system clock; all logic on posedge clkIn.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 sigIn  input  1  measured clock or divided-clock signal, asynchronous to clkIn.
REQ-006 en  input  1  measurement enable.
REQ-007 period  output  WIDTH  clkIn cycles between two consecutive detected rising edges of sigIn.
REQ-008 highTime  output  WIDTH  clkIn cycles from a detected rising edge to the next detected falling edge.
REQ-009 valid  output  1  period/highTime hold a measurement not yet accepted.
REQ-010 ready  input  1  consumer accepts the measurement on a cycle where valid && ready.
REQ-011 overrun  output  1  sticky: a completed measurement was dropped.
REQ-012 timeout  output  1  one-cycle pulse: no rising edge within the counter range.

Function
REQ-013 sigIn SHALL pass through a SYNC_STAGES-flop synchronizer; edge detection SHALL compare the last synchronizer stage with one further registered copy.
REQ-014 A rise (fall) SHALL be detected on the clkIn cycle where the current synchronized value is 1 (0) and the previous value is 0 (1).
REQ-015 The FSM SHALL have states ARM and MEASURE.
REQ-016 ARM: on a detected rise, the FSM SHALL clear both counters to 1 and go to MEASURE; no result is produced.
REQ-017 MEASURE: the period counter SHALL increment every cycle; the high counter SHALL increment until the first detected fall after the rise, then freeze.
REQ-018 MEASURE, on a detected rise: the block SHALL complete a measurement with period = the period counter value and highTime = the frozen high count, restart both counters at 1, and stay in MEASURE.
REQ-019 Period values SHALL equal t1 - t0, where t0 and t1 are the detection cycles of two consecutive rises; highTime SHALL equal tfall - t0.
REQ-020 If no fall occurs between the two rises, the measurement SHALL NOT be completed; the counters restart and no result is produced.
REQ-021 On completion: if valid == 0, or valid && ready in the same cycle, the block SHALL load period/highTime on the next edge and set valid = 1.
REQ-022 On completion with valid && !ready: the results SHALL be discarded, held outputs stay unchanged, and overrun SHALL be set to 1.
REQ-023 When valid && ready and there is no completion, valid SHALL clear on the next edge.
REQ-024 period/highTime SHALL be stable while valid == 1.
REQ-025 When the period counter reaches 2^WIDTH-1 in MEASURE without a rise:
- timeout SHALL pulse for one cycle;
- the FSM SHALL return to ARM;
- the counters SHALL stop, with no wrap-around.
REQ-026 en == 0 SHALL force ARM and hold the counters.
REQ-027 en == 0 SHALL NOT affect valid, period, highTime or overrun; the handshake SHALL still complete.
REQ-028 Deasserting en mid-period SHALL abandon that period; after re-enable, the first rise only arms.
REQ-029 Latency: a sigIn rise stable before a clkIn edge SHALL be detected SYNC_STAGES+1 cycles later; valid SHALL rise 1 cycle after the detecting cycle.
REQ-030 overrun SHALL clear only on reset.

Reset
REQ-031 When rstN is low, the block SHALL asynchronously set:
- state = ARM;
- counters and the synchronizer/edge flops = 0;
- period = 0, highTime = 0;
- valid = 0, overrun = 0, timeout = 0.
REQ-032 Reset asserted mid-measurement SHALL discard that measurement.
REQ-033 After reset release, the first detected rise SHALL only arm; the first result SHALL follow the second detected rise.

Verification
REQ-034 sigIn from a same-clock divider with 100 stages (low 50 cycles, high 51 cycles, period 101), en=1, ready=1 -> every result has period=101, highTime=51, starting from the second rise; overrun=0.
REQ-035 Same stimulus, ready=0 for 3 periods -> the first result is held unchanged, valid=1, overrun=1 after the second completion; after ready=1, valid clears and the next completion loads a fresh 101/51.
REQ-036 WIDTH=8, sigIn stuck at 0 after one rise -> timeout pulses once, 255 cycles after arming; then ARM, no valid.
REQ-037 Completion on the same cycle as valid && ready -> the new values load and valid stays 1 with no gap; overrun stays 0.
REQ-038 rstN pulsed low for 1 cycle mid-period while valid=1 -> all outputs are immediately 0; the next result appears only after two further rises.
REQ-039 en dropped for 20 cycles mid-period -> no result for the interrupted period; the period after re-arming reads 101.
